spi_tx_sequencer: RTL and testbench
===================================

# spi_tx_sequencer

Upstream feeder for the 12-bit `spi` top (ports `newd`, `din`, `dout`, `done`). It buffers 12-bit command words from a host in a FIFO and issues them one at a time to the SPI block via the `newd`/`din` handshake. It waits for `done` on each word, then returns the captured `dout` word to the host as a one-cycle valid pulse. Missing `done` responses are caught by a timeout with a sticky error flag.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `NEWD_CYCLES`, 40: clocks `newd` is held high per word; must exceed one `sclk` period of the SPI block.
- `GAP_CYCLES`, 4: minimum idle clocks between `done` and the next `newd`.
- `TIMEOUT_CYCLES`, 2000: clocks allowed in WAIT before abort.
- `clk`  in  1  system clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host write strobe.
- `wr_data`  in  12  host command word.
- `full`  out  1  FIFO full.
- `empty`  out  1  FIFO empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `newd`  out  1  new-data request to the SPI block.
- `din`  out  12  word to the SPI block.
- `done`  in  1  SPI transfer complete.
- `dout`  in  12  word received by the SPI block.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is valid.
- `rx_data`  out  12  captured `dout`.
- `busy`  out  1  high in any state other than IDLE.
- `ovf`  out  1  sticky; set by a write attempted while full.
- `tmo`  out  1  sticky; set by a timeout.
- `clr_err`  in  1  clears `ovf` and `tmo`.

## Operation
- FIFO: circular buffer with `$clog2(DEPTH)`-bit pointers that wrap naturally.
  - A write is accepted when `wr_en && !full`.
  - A write while full is dropped and sets `ovf`.
  - A write on the same cycle as a pop, while full, is accepted; `level` is unchanged.
- FSM states:
  - IDLE: when `!empty`, go to LOAD.
  - LOAD, 1 cycle: pop the FIFO head into the `din` register, then go to REQ.
  - REQ: `newd`=1 for exactly `NEWD_CYCLES` clocks, then go to WAIT. `din` is held stable from LOAD until the state exits WAIT.
  - WAIT: `newd`=0.
    - On `done`=1 sampled: `rx_data`<=`dout`, `rx_valid`=1 for the next cycle, go to GAP.
    - If the WAIT counter reaches `TIMEOUT_CYCLES`: set `tmo`, no `rx_valid`, go to GAP. The word is discarded, not retried.
  - GAP: count `GAP_CYCLES`. Stay in GAP while `done`=1. Then go to IDLE.
- A `done` observed outside WAIT is ignored.
- `clr_err` has priority below a same-cycle set: the flag remains 1.

## Timing
- Reset values:
  - FIFO empty, `level`=0, `full`=0, `empty`=1.
  - `newd`=0, `din`=0, `rx_valid`=0, `rx_data`=0, `busy`=0, `ovf`=0, `tmo`=0.
  - FSM in IDLE.
- Reset mid-operation, from any state: next cycle is IDLE, `newd` drops, and FIFO contents are discarded.
- Write to `newd`: a write at edge N makes `empty`=0 after N. LOAD is at N+1 and `newd` rises after edge N+2.
- Response capture: `done` sampled high at edge M gives `rx_valid`/`rx_data` after edge M, for exactly one cycle.
- Back-to-back spacing: the next `newd` rises no earlier than `GAP_CYCLES`+2 clocks after the `done` sample, and only after `done` has returned low.
- `full`, `empty`, and `level` are registered and update on the edge after a write or pop.

## Test plan
- Single word: after reset, write 0xA5C. Expect `din`=0xA5C and `newd` high for 40 clocks. With the SPI in loopback, expect `rx_valid` once with `rx_data`=0xA5C and `busy` returning to 0.
- Burst: write 8 words 0x001..0x008 back-to-back. Expect `full`=1 after the 8th write. Expect 8 transfers in order, 8 `rx_valid` pulses, and `level` decreasing to 0.
- Overflow: fill with 8 words while the SPI is stalled, then write 0xFFF. Expect `ovf`=1, the word dropped, and only 8 transfers. `clr_err` clears `ovf`.
- Timeout: model `done` tied 0 and write 0x123. Expect `tmo`=1 exactly 2000 clocks after WAIT entry, no `rx_valid`, and the next queued word then issued.
- Reset mid-transfer: assert `rst` during REQ with 3 words queued. Expect `newd`=0, `empty`=1, and `busy`=0 on the next cycle, and no further transfers.
- Simultaneous write and pop when full: expect the write accepted, `level` held at 8, and `ovf`=0.

Source files
------------

// File: rtl/spi_tx_sequencer_if.sv
// spi_tx_sequencer_if: host write port, SPI handshake and status signals of the sequencer
interface spi_tx_sequencer_if #(
    parameter int DEPTH = 8
);
    logic                   wr_en;
    logic [11:0]            wr_data;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;
    logic                   newd;
    logic [11:0]            din;
    logic                   done;
    logic [11:0]            dout;
    logic                   rx_valid;
    logic [11:0]            rx_data;
    logic                   busy;
    logic                   ovf;
    logic                   tmo;
    logic                   clr_err;

    modport master (
        output wr_en, wr_data, done, dout, clr_err,
        input  full, empty, level, newd, din, rx_valid, rx_data, busy, ovf, tmo
    );

    modport slave (
        input  wr_en, wr_data, done, dout, clr_err,
        output full, empty, level, newd, din, rx_valid, rx_data, busy, ovf, tmo
    );
endinterface

// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: FIFO-buffered command feeder for the 12-bit SPI block with done timeout
module spi_tx_sequencer #(
    parameter int DEPTH          = 8,
    parameter int NEWD_CYCLES    = 40,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input logic               clk,
    input logic               rst,
    spi_tx_sequencer_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = TIMEOUT_CYCLES > NEWD_CYCLES
                        ? (TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES)
                        : (NEWD_CYCLES > GAP_CYCLES ? NEWD_CYCLES : GAP_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   level;
    logic [11:0]   din_q, rx_data_q;
    logic          rx_valid_q, ovf_q, tmo_q;
    logic          full, empty, push, pop, cap, tmo_set;

    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    // a pop on the same edge frees the slot, so a write while full still lands
    assign push  = bus.wr_en && (!full || pop);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        pop     = 1'b0;
        cap     = 1'b0;
        tmo_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) state_n = LOAD;
            end
            LOAD: begin
                cnt_n   = '0;
                pop     = 1'b1;
                state_n = REQ;
            end
            REQ: if (cnt == CW'(NEWD_CYCLES - 1)) begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: if (bus.done) begin
                cap     = 1'b1;
                cnt_n   = '0;
                state_n = GAP;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                tmo_set = 1'b1;
                cnt_n   = '0;
                state_n = GAP;
            end
            GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
                cnt_n = bus.done ? cnt : '0;
                if (!bus.done) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wptr       <= '0;
            rptr       <= '0;
            level      <= '0;
            din_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wptr       <= push ? wptr + 1'b1 : wptr;
            rptr       <= pop ? rptr + 1'b1 : rptr;
            level      <= level + (AW+1)'(push) - (AW+1)'(pop);
            din_q      <= pop ? mem[rptr] : din_q;
            rx_data_q  <= cap ? bus.dout : rx_data_q;
            rx_valid_q <= cap;
            ovf_q      <= (bus.wr_en && !push) || (ovf_q && !bus.clr_err);
            tmo_q      <= tmo_set || (tmo_q && !bus.clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.wr_data;
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.newd     = state == REQ;
    assign bus.din      = din_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = state != IDLE;
    assign bus.ovf      = ovf_q;
    assign bus.tmo      = tmo_q;
endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb_spi_tx_sequencer: directed vectors, corner sequences and a queue-model random run against a loopback SPI responder
module tb_spi_tx_sequencer;
    localparam int DEPTH = 8;
    localparam int NEWD  = 40;
    localparam int GAP   = 4;
    localparam int TMO   = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_tx_sequencer_if #(.DEPTH(DEPTH)) bus();

    spi_tx_sequencer #(
        .DEPTH(DEPTH), .NEWD_CYCLES(NEWD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errs = 0, checks = 0, cyc = 0, starts = 0, rxs = 0;
    logic last_newd = 1'b0;
    bit stall = 0, rnd = 0, stray = 0, in_wait = 0, model_on = 0, m_ovf = 0;
    int cd = 0, done_left = 0, resp_delay = 3, done_len = 1, hi = 0;
    logic [11:0] mask = '0;
    logic [11:0] mq[$];
    logic [11:0] exp_rx[$];

    typedef struct packed {
        logic        wr;
        logic [11:0] data;
        logic [3:0]  level;
        logic        empty;
        logic        busy;
        logic        newd;
        logic [11:0] din;
    } vec_t;
    vec_t tv[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a plain queue of accepted words, popped whenever a transfer starts
    task automatic model_step(input bit rise, input bit fall);
        int mlev = mq.size();
        bit acc = bus.wr_en && (mlev < DEPTH || rise);
        if (rise) begin
            chk("start_with_word", 32'(mlev > 0), 1);
            if (mlev > 0) begin
                chk("din_order", 32'(bus.din), 32'(mq[0]));
                exp_rx.push_back(mq[0] ^ mask);
                mq.delete(0);
            end
            hi = 0;
        end
        if (bus.newd) hi++;
        if (fall) chk("newd_width", hi, NEWD);
        if (bus.rx_valid) begin
            chk("rx_expected", 32'(exp_rx.size() > 0), 1);
            if (exp_rx.size() > 0) chk("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
        end
        if (acc) mq.push_back(bus.wr_data);
        m_ovf = (bus.wr_en && !acc) || (m_ovf && !bus.clr_err);
        chk("level", 32'(bus.level), mq.size());
        chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
        chk("tmo", 32'(bus.tmo), 0);
    endtask

    // One clock: sample after the edge, update model, then drive the SPI responder for the next edge
    task automatic tick();
        bit rise, fall;
        @(posedge clk);
        #1;
        cyc++;
        rise = bus.newd && !last_newd;
        fall = !bus.newd && last_newd;
        last_newd = bus.newd;
        if (rise) starts++;
        if (bus.rx_valid) rxs++;
        if (model_on) model_step(rise, fall);
        if (fall) begin
            in_wait = 1;
            cd = rnd ? int'($urandom_range(0, 5)) : resp_delay;
        end
        if (in_wait && !stall) begin
            if (cd == 0) begin
                in_wait = 0;
                done_left = rnd ? int'($urandom_range(1, 6)) : done_len;
            end else cd--;
        end else if (stray && !in_wait && done_left == 0 && $urandom_range(0, 99) == 0) done_left = 1;
        bus.done = done_left > 0;
        bus.dout = done_left > 0 ? bus.din ^ mask : 12'($urandom);
        if (done_left > 0) done_left--;
    endtask

    function automatic bit cond(input int what);
        case (what)
            0: return bus.newd;
            1: return !bus.newd;
            2: return bus.rx_valid;
            3: return !bus.busy && bus.empty;
            4: return bus.tmo;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_on(input int what, input int maxc, input string nm);
        int n = 0;
        while (!cond(what) && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, 32'(cond(what)), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.clr_err = 1'b0;
        bus.done = 1'b0;
        in_wait = 0;
        done_left = 0;
        tick();
        rst = 1'b0;
        mq.delete();
        exp_rx.delete();
        m_ovf = 0;
        hi = 0;
        starts = 0;
        rxs = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, w;
        tv[0] = '{1'b1, 12'hA5C, 4'd1, 1'b0, 1'b0, 1'b0, 12'h000};
        tv[1] = '{1'b0, 12'h000, 4'd1, 1'b0, 1'b1, 1'b0, 12'h000};
        tv[2] = '{1'b0, 12'h000, 4'd0, 1'b1, 1'b1, 1'b1, 12'hA5C};
        tv[3] = '{1'b1, 12'h3C3, 4'd1, 1'b0, 1'b1, 1'b1, 12'hA5C};
        tv[4] = '{1'b0, 12'h000, 4'd1, 1'b0, 1'b1, 1'b1, 12'hA5C};
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.clr_err = 1'b0;
        bus.done = 1'b0;
        bus.dout = '0;

        do_reset();
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_newd", 32'(bus.newd), 0);
        chk("rst_din", 32'(bus.din), 0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_rx_data", 32'(bus.rx_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_tmo", 32'(bus.tmo), 0);

        // Single word: write-to-newd latency and loopback response
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = tv[i].wr;
            bus.wr_data = tv[i].data;
            tick();
            chk($sformatf("vec%0d_level", i), 32'(bus.level), 32'(tv[i].level));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tv[i].empty));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tv[i].busy));
            chk($sformatf("vec%0d_newd", i), 32'(bus.newd), 32'(tv[i].newd));
            chk($sformatf("vec%0d_din", i), 32'(bus.din), 32'(tv[i].din));
        end
        bus.wr_en = 1'b0;
        begin
            int n = 3;
            while (bus.newd && n < 100) begin
                tick();
                if (bus.newd) n++;
            end
            chk("a_newd_width", n, NEWD);
        end
        wait_on(2, 100, "a_rx1_seen");
        m = cyc;
        chk("a_rx1_data", 32'(bus.rx_data), 32'h A5C);
        wait_on(0, 100, "a_start2_seen");
        chk("a_gap_spacing", cyc - m, GAP + 2);
        chk("a_din2", 32'(bus.din), 32'h3C3);
        wait_on(2, 100, "a_rx2_seen");
        chk("a_rx2_data", 32'(bus.rx_data), 32'h3C3);
        tick();
        chk("a_rx_pulse_width", 32'(bus.rx_valid), 0);
        wait_on(3, 50, "a_idle");
        chk("a_busy_low", 32'(bus.busy), 0);
        chk("a_rx_count", rxs, 2);

        // Burst, overflow, clr_err priority, and write+pop while full
        do_reset();
        stall = 1;
        bus.wr_en = 1'b1;
        bus.wr_data = 12'h0FF;
        tick();
        bus.wr_en = 1'b0;
        wait_on(0, 10, "b_start0");
        for (int i = 1; i <= 8; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 12'(i);
            tick();
        end
        chk("b_full", 32'(bus.full), 1);
        chk("b_level8", 32'(bus.level), 8);
        bus.wr_data = 12'hFFF;
        bus.clr_err = 1'b1;
        tick();
        chk("b_ovf_beats_clr", 32'(bus.ovf), 1);
        chk("b_level_after_ovf", 32'(bus.level), 8);
        bus.wr_en = 1'b0;
        tick();
        bus.clr_err = 1'b0;
        chk("b_ovf_cleared", 32'(bus.ovf), 0);
        stall = 0;
        wait_on(2, 50, "b_rx0_seen");
        chk("b_rx0_data", 32'(bus.rx_data), 32'h0FF);
        repeat (GAP + 1) tick();
        bus.wr_en = 1'b1;
        bus.wr_data = 12'h009;
        tick();
        bus.wr_en = 1'b0;
        chk("b_simul_pop", 32'(bus.newd), 1);
        chk("b_simul_din", 32'(bus.din), 32'h001);
        chk("b_simul_level", 32'(bus.level), 8);
        chk("b_simul_full", 32'(bus.full), 1);
        chk("b_simul_ovf", 32'(bus.ovf), 0);
        for (int i = 1; i <= 9; i++) begin
            wait_on(2, 150, "b_rx_seen");
            chk($sformatf("b_rx%0d_data", i), 32'(bus.rx_data), 32'(i));
            tick();
        end
        wait_on(3, 100, "b_drained");
        chk("b_level0", 32'(bus.level), 0);
        repeat (100) tick();
        chk("b_starts", starts, 10);
        chk("b_rx_count", rxs, 10);

        // Timeout: stalled done, word dropped, next word still issued
        do_reset();
        stall = 1;
        bus.wr_en = 1'b1;
        bus.wr_data = 12'h123;
        tick();
        bus.wr_data = 12'h456;
        tick();
        bus.wr_en = 1'b0;
        wait_on(0, 10, "c_start");
        chk("c_din", 32'(bus.din), 32'h123);
        wait_on(1, 100, "c_wait_entry");
        w = cyc;
        wait_on(4, TMO + 50, "c_tmo_seen");
        chk("c_tmo_latency", cyc - w, TMO);
        chk("c_no_rx", rxs, 0);
        stall = 0;
        in_wait = 0;
        wait_on(0, 50, "c_next_start");
        chk("c_next_din", 32'(bus.din), 32'h456);
        wait_on(2, 150, "c_rx_seen");
        chk("c_rx_data", 32'(bus.rx_data), 32'h456);
        chk("c_tmo_sticky", 32'(bus.tmo), 1);
        chk("c_rx_count", rxs, 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("c_tmo_cleared", 32'(bus.tmo), 0);

        // Reset during REQ with three words queued
        do_reset();
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 12'(12'h100 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        wait_on(0, 10, "d_start");
        repeat (3) tick();
        chk("d_level3", 32'(bus.level), 3);
        chk("d_in_req", 32'(bus.newd), 1);
        do_reset();
        chk("d_newd", 32'(bus.newd), 0);
        chk("d_empty", 32'(bus.empty), 1);
        chk("d_busy", 32'(bus.busy), 0);
        chk("d_level", 32'(bus.level), 0);
        stall = 0;
        repeat (100) tick();
        chk("d_no_transfers", starts, 0);

        // Random traffic against the queue model, with stray done pulses
        do_reset();
        rnd = 1;
        stray = 1;
        mask = 12'($urandom);
        model_on = 1;
        for (int i = 0; i < 4000; i++) begin
            bus.wr_en = $urandom_range(0, 99) < (i < 1500 ? 4 : 30);
            bus.wr_data = 12'($urandom);
            bus.clr_err = $urandom_range(0, 49) == 0;
            tick();
        end
        bus.wr_en = 1'b0;
        bus.clr_err = 1'b0;
        wait_on(3, 3000, "r_drained");
        chk("r_queue_empty", mq.size(), 0);
        chk("r_rx_pending", exp_rx.size(), 0);
        chk("r_rx_count", rxs, starts);
        model_on = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
